// File: rtl/sync_fifo_pkg.sv
// Shared widths and status payload for the single-clock FIFO family.
package sync_fifo_pkg;

    function automatic int unsigned ptr_w(input int unsigned depth);
        int unsigned w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage

// File: rtl/fifo_wrap_ctr.sv
// Modulo-MAX pointer: advances on inc, wraps from MAX-1 back to 0.
module fifo_wrap_ctr
    import sync_fifo_pkg::*;
#(
    parameter int unsigned MAX = 8,
    localparam int unsigned PW = ptr_w(MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [PW-1:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (inc) begin
            value <= (value == PW'(MAX - 1)) ? '0 : value + PW'(1);
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with arbitrary depth, occupancy count, thresholds and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; default is registered read.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AFULL_TH  = DEPTH - 2,
    parameter int unsigned AEMPTY_TH = 2,
    localparam int unsigned CW       = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data_in,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data_out,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam fifo_status_t STATUS_RST = '{full: 1'b0, empty: 1'b1,
                                            almost_full: 1'b0, almost_empty: 1'b1};

    if (DEPTH < 2) begin : g_chk_depth
        $error("sync_fifo_param: DEPTH must be >= 2");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_chk_afull
        $error("sync_fifo_param: AFULL_TH must be in 1..DEPTH");
    end
    if (AEMPTY_TH > DEPTH - 1) begin : g_chk_aempty
        $error("sync_fifo_param: AEMPTY_TH must be in 0..DEPTH-1");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    fifo_status_t     status_q;
    logic             wr_acc_c;
    logic             rd_acc_c;
    logic [CW-1:0]    count_nxt_c;

    assign full         = status_q.full;
    assign empty        = status_q.empty;
    assign almost_full  = status_q.almost_full;
    assign almost_empty = status_q.almost_empty;

    // Acceptance uses the registered flags, so full+rd frees a slot only next cycle.
    assign wr_acc_c = wr_en & ~status_q.full;
    assign rd_acc_c = rd_en & ~status_q.empty;

    always_comb begin
        count_nxt_c = count;
        if (wr_acc_c && !rd_acc_c) begin
            count_nxt_c = count + CW'(1);
        end else if (rd_acc_c && !wr_acc_c) begin
            count_nxt_c = count - CW'(1);
        end
    end

    fifo_wrap_ctr #(.MAX(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc   (wr_acc_c),
        .value (wr_ptr)
    );

    fifo_wrap_ctr #(.MAX(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc   (rd_acc_c),
        .value (rd_ptr)
    );

    // Storage is not reset; reset only blocks the write landing at that edge.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc_c) begin
            mem[wr_ptr] <= wr_data_in;
        end
    end

    // Flags follow the next-state count so they line up with count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            status_q  <= STATUS_RST;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count                 <= count_nxt_c;
            status_q.full         <= (count_nxt_c == CW'(DEPTH));
            status_q.empty        <= (count_nxt_c == '0);
            status_q.almost_full  <= (count_nxt_c >= CW'(AFULL_TH));
            status_q.almost_empty <= (count_nxt_c <= CW'(AEMPTY_TH));
            overflow              <= wr_en & status_q.full;
            underflow             <= rd_en & status_q.empty;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data_out = mem[rd_ptr];
    assign rd_valid    = ~status_q.empty;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_out <= '0;
            rd_valid    <= 1'b0;
        end else begin
            rd_valid <= rd_acc_c;
            if (rd_acc_c) begin
                rd_data_out <= mem[rd_ptr];
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param against a queue model.
// Follows SYNC_FIFO_FWFT_EN to select the expected read behaviour.
module tb_sync_fifo_param;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 6;
    localparam int unsigned AF    = 5;
    localparam int unsigned AE    = 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data_in;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data_out;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int errors = 0;

    sync_fifo_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AF), .AEMPTY_TH(AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data_in   (wr_data_in),
        .rd_en        (rd_en),
        .rd_data_out  (rd_data_out),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of stored words plus the last registered read.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ovf;
    logic             m_unf;
    bit               synced = 1'b0;
    bit               was_full;
    bit               was_empty;
    logic [WIDTH-1:0] popped;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            synced  = 1'b1;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            m_ovf     = wr_en && was_full;
            m_unf     = rd_en && was_empty;
            m_valid   = 1'b0;
            if (rd_en && !was_empty) begin
                popped  = q.pop_front();
                m_data  = popped;
                m_valid = 1'b1;
            end
            if (wr_en && !was_full) q.push_back(wr_data_in);
        end
    end

    always @(negedge clk) begin
        if (synced) begin
            check("count", int'(count), q.size());
            check("full", int'(full), int'(q.size() == DEPTH));
            check("empty", int'(empty), int'(q.size() == 0));
            check("almost_full", int'(almost_full), int'(q.size() >= AF));
            check("almost_empty", int'(almost_empty), int'(q.size() <= AE));
            check("overflow", int'(overflow), int'(m_ovf));
            check("underflow", int'(underflow), int'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
            check("rd_valid", int'(rd_valid), int'(q.size() != 0));
            if (q.size() != 0) check("rd_data_out", int'(rd_data_out), int'(q[0]));
`else
            check("rd_valid", int'(rd_valid), int'(m_valid));
            check("rd_data_out", int'(rd_data_out), int'(m_data));
`endif
        end
    end

    task automatic cyc(input logic w, input logic [WIDTH-1:0] d, input logic r);
        wr_en      = w;
        wr_data_in = d;
        rd_en      = r;
        @(negedge clk);
    endtask

    // Read one word and pin its value: head before the pop (FWFT) or data after it.
    task automatic read_expect(input string name, input int exp);
`ifdef SYNC_FIFO_FWFT_EN
        check({name, "_valid"}, int'(rd_valid), 1);
        check(name, int'(rd_data_out), exp);
        cyc(1'b0, '0, 1'b1);
`else
        cyc(1'b0, '0, 1'b1);
        check({name, "_valid"}, int'(rd_valid), 1);
        check(name, int'(rd_data_out), exp);
`endif
    endtask

    initial begin
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_data_in = '0;
        rd_en      = 1'b0;
        @(negedge clk);
        cyc(1'b0, '0, 1'b0);
        rst = 1'b0;
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_aempty", int'(almost_empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_valid", int'(rd_valid), 0);

        // Fill to full, then one rejected write.
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, WIDTH'(8'h11 + i), 1'b0);
            check("fill_count", int'(count), i + 1);
            check("fill_aempty", int'(almost_empty), int'(i == 0));
            check("fill_afull", int'(almost_full), int'(i >= 4));
            check("fill_full", int'(full), int'(i == 5));
        end
        cyc(1'b1, 8'h17, 1'b0);
        check("ovf_pulse", int'(overflow), 1);
        check("ovf_count", int'(count), 6);

        // Drain in order, then one rejected read.
        for (int i = 0; i < 6; i++) read_expect("drain", 8'h11 + i);
        check("drain_empty", int'(empty), 1);
        cyc(1'b0, '0, 1'b1);
        check("unf_pulse", int'(underflow), 1);
        check("unf_valid", int'(rd_valid), 0);
`ifndef SYNC_FIFO_FWFT_EN
        check("unf_hold", int'(rd_data_out), 8'h16);
`endif

        // Steady-state streaming at count 3 across pointer wrap.
        for (int i = 0; i < 3; i++) cyc(1'b1, WIDTH'(8'h20 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            int exp;
            exp = (i < 3) ? (8'h20 + i) : (8'h30 + i - 3);
`ifdef SYNC_FIFO_FWFT_EN
            check("stream_head", int'(rd_data_out), exp);
            cyc(1'b1, WIDTH'(8'h30 + i), 1'b1);
`else
            cyc(1'b1, WIDTH'(8'h30 + i), 1'b1);
            check("stream_data", int'(rd_data_out), exp);
`endif
            check("stream_count", int'(count), 3);
        end

        // Simultaneous write/read at full and at empty.
        for (int i = 0; i < 3; i++) cyc(1'b1, WIDTH'(8'h50 + i), 1'b0);
        check("t4_full", int'(full), 1);
        cyc(1'b1, 8'hAA, 1'b1);
        check("t4_full_count", int'(count), 5);
        check("t4_full_ovf", int'(overflow), 1);
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1);
        check("t4_empty", int'(empty), 1);
        cyc(1'b1, 8'hBB, 1'b1);
        check("t4_empty_count", int'(count), 1);
        check("t4_empty_unf", int'(underflow), 1);
        read_expect("t4_bb", 8'hBB);

        // Reset with a concurrent write discards everything.
        for (int i = 0; i < 4; i++) cyc(1'b1, WIDTH'(8'h61 + i), 1'b0);
        rst = 1'b1;
        cyc(1'b1, 8'hEE, 1'b0);
        rst = 1'b0;
        check("t5_count", int'(count), 0);
        check("t5_empty", int'(empty), 1);
        check("t5_valid", int'(rd_valid), 0);
        cyc(1'b1, 8'h77, 1'b0);
        read_expect("t5_first", 8'h77);

        // Random traffic with occasional reset.
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            cyc(1'($urandom_range(0, 99) < 55), WIDTH'($urandom), 1'($urandom_range(0, 99) < 50));
        end
        rst = 1'b0;
        cyc(1'b0, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised successor to the team's gray-pointer FIFO.
- Used where producer and consumer share one clock domain, so no pointer synchronisers are needed.
- Adds features the previous generation lacks: arbitrary (non-power-of-2) depth, an occupancy count, programmable almost-full/almost-empty thresholds, a read-valid strobe, and overflow/underflow error pulses.
- Read data holds its last value; it is never driven to Z.

Parameters:
- WIDTH, 8: data word width in bits, >=1.
- DEPTH, 8: number of storage entries, >=2; need not be a power of two.
- AFULL_TH, DEPTH-2: almost_full asserts when count >= AFULL_TH. Range 1..DEPTH.
- AEMPTY_TH, 2: almost_empty asserts when count <= AEMPTY_TH. Range 0..DEPTH-1.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write request.
- wr_data_in  input  WIDTH  write data, sampled on the accepting edge.
- rd_en  input  1  read request; acts as pop/ack in FWFT mode.
- rd_data_out  output  WIDTH  read data.
- rd_valid  output  1  rd_data_out holds a freshly popped word.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_TH.
- almost_empty  output  1  count <= AEMPTY_TH.
- count  output  CW  occupancy, where CW = $clog2(DEPTH+1).
- overflow  output  1  one-cycle pulse: write rejected.
- underflow  output  1  one-cycle pulse: read rejected.

Behaviour:
- Reset (rst=1 at posedge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Outputs: empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, rd_data_out=0, overflow=0, underflow=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored words at that edge; rst has priority over wr_en and rd_en.
- Acceptance:
  - wr_acc = wr_en & !full.
  - rd_acc = rd_en & !empty.
  - Both use the registered flags from the start of the cycle.
- Full with wr_en and rd_en together: the read is accepted, the write is rejected, overflow pulses, count drops by 1. No pass-through.
- Empty with wr_en and rd_en together: the write is accepted, the read is rejected, underflow pulses, count becomes 1.
- Write: on wr_acc, mem[wr_ptr] <= wr_data_in and wr_ptr advances.
- Pointers: binary, range 0..DEPTH-1. On advance, a pointer at DEPTH-1 wraps to 0, otherwise it increments by 1.
- Count update:
  - +1 on wr_acc & !rd_acc.
  - -1 on rd_acc & !wr_acc.
  - Unchanged when both or neither are accepted.
- Flags (full, empty, almost_*) are registered and computed from the next-state count, so they are valid in the same cycle count updates. There is no extra flag latency.
- Standard (non-FWFT) read:
  - On rd_acc, rd_data_out <= mem[rd_ptr] and rd_valid <= 1: one-cycle latency.
  - Otherwise rd_valid <= 0 and rd_data_out holds its value.
- overflow <= wr_en & full. underflow <= rd_en & empty. Each is a single-cycle registered pulse and is not sticky.
- Threshold parameters outside their legal range are rejected by an elaboration-time check ($error).

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word fall-through):
  - rd_data_out = mem[rd_ptr], combinational from the memory read port.
  - rd_valid = !empty.
  - rd_en acknowledges/pops the current head. The next word appears in the cycle after the pop.
  - A word written into an empty FIFO is visible the cycle after the write.
- Undefined: the standard registered read with one-cycle latency described in Behaviour.
- Flags, count and error pulses are identical in both modes.

Decomposition:
- Package sync_fifo_pkg:
  - function ptr_w(depth) returning max(1,$clog2(depth)).
  - function cnt_w(depth) returning $clog2(depth+1).
  - typedef of a fifo_status struct {full, empty, almost_full, almost_empty} for downstream reuse.
- Sub-module fifo_wrap_ctr, parameterised by MAX:
  - A modulo-MAX pointer with inc input and synchronous active-high reset.
  - Instantiated twice, for wr_ptr and rd_ptr.

Test Plan (WIDTH=8, DEPTH=6, AFULL_TH=5, AEMPTY_TH=1, both macro settings):
1. Reset, then write 0x11..0x16 on 6 consecutive cycles:
   - count goes 1..6.
   - almost_empty deasserts at count 2.
   - almost_full asserts at count 5.
   - full=1 at count 6.
   - A 7th write gives overflow=1 for one cycle and count stays 6.
2. From full, read 6 words:
   - Data reads 0x11..0x16 in order (1-cycle latency standard, 0 latency FWFT).
   - empty=1 after the 6th read.
   - An extra read gives underflow=1, rd_valid=0 and rd_data_out holds 0x16 (standard mode).
3. Write and read together for 20 cycles starting at count 3:
   - count stays 3.
   - Pointers wrap past 5 to 0 without loss or reorder.
4. Simultaneous wr_en/rd_en at full:
   - count 6 goes to 5.
   - overflow=1 and the write is dropped.
   - At empty: count 0 goes to 1, underflow=1, and the written word reads out next.
5. Assert rst after writing 4 words with wr_en=1 in the same cycle:
   - Next cycle count=0, empty=1, no write is stored.
   - A subsequent read returns the first post-reset word.
